uart_rx_deframer: RTL and testbench

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

---
 rtl/uart_rx_deframer.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// UART byte-stream deframer: SYNC, LEN, payload, XOR checksum; good payloads replayed on a ready/valid stream.
// Optional inter-byte timeout is compiled in with `define UART_RX_DEFRAMER_TIMEOUT_EN.
module uart_rx_deframer #(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_done,
  input  logic       in_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_bad,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_rx_deframer: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

  state_t      r_state;
  logic [7:0]  r_len;
  logic [7:0]  r_idx;
  logic [7:0]  r_rd;
  logic [7:0]  r_csum;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_frame_ok;
  logic        r_frame_bad;
  logic        r_overrun;
  logic [7:0]  r_buf [MAX_LEN];

  logic        w_in_frame;
  logic        w_len_bad;
  logic        w_accept;
  logic [7:0]  w_rd_next;
  logic        w_timeout;

  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
  assign w_len_bad  = (in_data == 8'd0) || (32'(in_data) > MAX_LEN);
  assign w_accept   = r_out_valid && out_ready;
  assign w_rd_next  = r_rd + 8'd1;

`ifdef UART_RX_DEFRAMER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo;

  // Idle time since the last accepted byte; held at zero outside a frame.
  always_ff @(posedge clk) begin
    if (rst || in_done || !w_in_frame) r_tmo <= '0;
    else                               r_tmo <= r_tmo + 1'b1;
  end

  assign w_timeout = w_in_frame && (r_tmo == TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (r_state == S_PAYLOAD && in_done && !in_err) r_buf[r_idx[IDX_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= 8'd0;
      r_idx       <= 8'd0;
      r_rd        <= 8'd0;
      r_csum      <= 8'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_bad <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_bad <= 1'b0;
      r_overrun   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_done && in_data == SYNC_BYTE) r_state <= S_LEN;
        end
        S_LEN, S_PAYLOAD, S_CSUM: begin
          if (in_err) begin
            r_frame_bad <= 1'b1;
            r_state     <= S_IDLE;
          end else if (in_done) begin
            if (r_state == S_LEN) begin
              if (w_len_bad) begin
                r_frame_bad <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_len   <= in_data;
                r_csum  <= in_data;
                r_idx   <= 8'd0;
                r_state <= S_PAYLOAD;
              end
            end else if (r_state == S_PAYLOAD) begin
              r_csum <= r_csum ^ in_data;
              r_idx  <= r_idx + 8'd1;
              if (r_idx + 8'd1 == r_len) r_state <= S_CSUM;
            end else if (in_data == r_csum) begin
              // Preload the first payload byte so out_valid rises with valid data.
              r_frame_ok  <= 1'b1;
              r_rd        <= 8'd0;
              r_out_data  <= r_buf[0];
              r_out_last  <= (r_len == 8'd1);
              r_out_valid <= 1'b1;
              r_state     <= S_DRAIN;
            end else begin
              r_frame_bad <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_frame_bad <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (in_done) r_overrun <= 1'b1;
          if (w_accept) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_rd       <= w_rd_next;
              r_out_data <= r_buf[w_rd_next[IDX_W-1:0]];
              r_out_last <= (w_rd_next + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign frame_ok  = r_frame_ok;
  assign frame_bad = r_frame_bad;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: good/bad frames, length limits, back-pressure, errors, reset, timeout.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_done = 1'b0;
  logic       in_err = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_last, frame_ok, frame_bad, overrun, busy;

  int checks = 0;
  int errors = 0;
  int n_ok = 0, n_bad = 0, n_ovr = 0, n_vld = 0;

  uart_rx_deframer #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_done(in_done), .in_err(in_err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok(frame_ok), .frame_bad(frame_bad), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_ok)  n_ok++;
    if (frame_bad) n_bad++;
    if (overrun)   n_ovr++;
    if (out_valid) n_vld++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data = b;
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
  endtask

  task automatic send_err();
    in_err = 1'b1;
    tick();
    in_err = 1'b0;
  endtask

  task automatic test_reset();
    int bad0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if ({out_valid, out_last, frame_ok, frame_bad, overrun, busy} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {out_valid, out_last, frame_ok, frame_bad, overrun, busy}); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    bad0 = n_bad;
    send(8'h11); send_err(); send(8'h5A); tick();
    checks++; if (busy !== 1'b0 || n_bad !== bad0) begin errors++; $display("FAIL idle_ignore: busy %b bad %0d want 0 0", busy, n_bad - bad0); end
  endtask

  task automatic test_good_frame();
    int ok0;
    ok0 = n_ok;
    out_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h44);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL good_pre_csum: busy %b valid %b want 1 0", busy, out_valid); end
    send(8'h74);
    checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL good_ok: got %b want 1", frame_ok); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin errors++; $display("FAIL good_b0: v %b d %h l %b want 1 11 0", out_valid, out_data, out_last); end
    tick();
    checks++; if (frame_ok !== 1'b0 || out_data !== 8'h22 || out_last !== 1'b0) begin errors++; $display("FAIL good_b1: ok %b d %h l %b want 0 22 0", frame_ok, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h44 || out_last !== 1'b1) begin errors++; $display("FAIL good_b2: v %b d %h l %b want 1 44 1", out_valid, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || n_ok - ok0 !== 1) begin errors++; $display("FAIL good_end: v %b busy %b oks %0d want 0 0 1", out_valid, busy, n_ok - ok0); end
  endtask

  task automatic test_bad_csum();
    int v0;
    v0 = n_vld;
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    checks++; if (frame_bad !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bad_csum: bad %b busy %b want 1 0", frame_bad, busy); end
    tick();
    checks++; if (frame_bad !== 1'b0 || n_vld !== v0) begin errors++; $display("FAIL bad_csum_after: bad %b valid_cycles %0d want 0 0", frame_bad, n_vld - v0); end
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    checks++; if (frame_ok !== 1'b1 || out_data !== 8'h5A || out_last !== 1'b1) begin errors++; $display("FAIL bad_then_good: ok %b d %h l %b want 1 5a 1", frame_ok, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bad_then_good_end: v %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_len_limits();
    send(8'hA5); send(8'h00);
    checks++; if (frame_bad !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len_zero: bad %b busy %b want 1 0", frame_bad, busy); end
    send(8'hA5); send(8'h11);
    checks++; if (frame_bad !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len_17: bad %b busy %b want 1 0", frame_bad, busy); end
    send(8'hA5); send(8'h10);
    checks++; if (frame_bad !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL len_16: bad %b busy %b want 0 1", frame_bad, busy); end
    send_err();
    checks++; if (frame_bad !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len_16_err: bad %b busy %b want 1 0", frame_bad, busy); end
  endtask

  task automatic test_stall_overrun();
    int ovr0;
    ovr0 = n_ovr;
    out_ready = 1'b0;
    send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h64);
    checks++; if (frame_ok !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hAB) begin errors++; $display("FAIL stall_start: ok %b v %b d %h want 1 1 ab", frame_ok, out_valid, out_data); end
    tick(); tick();
    send(8'h55);
    checks++; if (overrun !== 1'b1 || out_data !== 8'hAB) begin errors++; $display("FAIL overrun: ovr %b d %h want 1 ab", overrun, out_data); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (overrun !== 1'b0 || n_ovr - ovr0 !== 1 || out_valid !== 1'b1 || out_data !== 8'hAB || out_last !== 1'b0) begin errors++; $display("FAIL stall_hold: ovrs %0d v %b d %h l %b want 1 1 ab 0", n_ovr - ovr0, out_valid, out_data, out_last); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hCD || out_last !== 1'b1) begin errors++; $display("FAIL stall_b1: v %b d %h l %b want 1 cd 1", out_valid, out_data, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_end: v %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_err_and_reset();
    send(8'hA5); send(8'h04); send(8'h01);
    send_err();
    checks++; if (frame_bad !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_payload: bad %b busy %b want 1 0", frame_bad, busy); end
    send(8'hA5); send(8'h02);
    in_err = 1'b1; send(8'h33); in_err = 1'b0;
    checks++; if (frame_bad !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_wins: bad %b busy %b want 1 0", frame_bad, busy); end
    send(8'hA5); send(8'h04); send(8'h01);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({out_valid, out_last, frame_ok, frame_bad, overrun, busy} !== 6'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rst_payload: flags %b d %h want 000000 00", {out_valid, out_last, frame_ok, frame_bad, overrun, busy}, out_data); end
    out_ready = 1'b0;
    send(8'hA5); send(8'h01); send(8'h77); send(8'h76);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rst_drain: v %b busy %b d %h want 0 0 00", out_valid, busy, out_data); end
    out_ready = 1'b1;
    send(8'hA5); send(8'h01); send(8'h3C); send(8'h3D);
    checks++; if (frame_ok !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL rst_recover: ok %b d %h want 1 3c", frame_ok, out_data); end
    tick();
  endtask

  task automatic test_timeout();
    int bad0;
    int k;
    bad0 = n_bad;
    send(8'hA5); send(8'h02); send(8'h01);
`ifdef UART_RX_DEFRAMER_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (frame_bad) begin k = i; break; end
    end
    checks++; if (k !== 50) begin errors++; $display("FAIL timeout: pulse after %0d cycles want 50", k); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy %b want 0", busy); end
`else
    k = 0;
    for (int i = 0; i < 1000; i++) tick();
    checks++; if (n_bad !== bad0) begin errors++; $display("FAIL no_timeout: pulses %0d want 0", n_bad - bad0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL no_timeout_busy: busy %b want 1 (k=%0d)", busy, k); end
    rst = 1'b1; tick(); rst = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_limits();
    test_stall_overrun();
    test_err_and_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
